sdram_req_scheduler: RTL
========================

// Module: sdram_req_scheduler
// PURPOSE
// Front-end scheduler for the SDRAM controller. Arbitrates three command sources into one
// registered valid/ready command stream: the FPGA write port, the FPGA read port and an
// internal periodic refresh timer. Write/read ties are broken round-robin. Refresh is
// deferred while traffic is present, and forced once the backlog reaches its limit.
// PARAMETERS
// ADDR_WIDTH        23    FPGA word address width (bank+row+col = 2+12+9)
// DATA_WIDTH        32    write data width
// REFRESH_INTERVAL  1296  clk cycles per refresh tick (166 MHz * 64 ms / 8192 rows)
// MAX_PENDING       8     refresh backlog that forces refresh priority (>=1)
// PORTS
// clk           in   1            system clock, all logic on rising edge
// reset_n       in   1            synchronous active-low reset
// wr_req        in   1            write request, held until wr_ack
// wr_addr       in   ADDR_WIDTH   write address, stable while wr_req
// wr_data       in   DATA_WIDTH   write data, stable while wr_req
// wr_ack        out  1            1-cycle pulse: write request captured
// rd_req        in   1            read request, held until rd_ack
// rd_addr       in   ADDR_WIDTH   read address, stable while rd_req
// rd_ack        out  1            1-cycle pulse: read request captured
// cmd_valid     out  1            command to controller valid
// cmd_ready     in   1            controller accepts command
// cmd_op        out  2            00 write, 01 read, 10 refresh, 11 unused
// cmd_addr      out  ADDR_WIDTH   command address (0 for refresh)
// cmd_data      out  DATA_WIDTH   write data (0 for read/refresh)
// ref_pending   out  $clog2(MAX_PENDING+1)  refresh ticks not yet issued
// ref_overflow  out  1            sticky: a tick arrived while ref_pending==MAX_PENDING
// BEHAVIOUR
// - Reset (reset_n=0 at a clk edge): all outputs 0, tick counter 0, state IDLE, last_grant=READ
//   (so the first write/read tie grants WRITE). Mid-operation reset drops any held command;
//   the requester it was acked for is not replayed.
// - Tick counter: counts 0..REFRESH_INTERVAL-1 and wraps to 0. Each wrap is one tick.
// - On a tick: if ref_pending<MAX_PENDING, ref_pending+1; otherwise ref_pending holds and
//   ref_overflow<=1. ref_overflow clears only on reset.
// - State machine, two states:
//   IDLE:  evaluate in priority order; the first match wins:
//     a) ref_pending==MAX_PENDING                 -> load REFRESH
//     b) wr_req & rd_req                          -> load the op opposite to last_grant
//     c) wr_req only / rd_req only                -> load WRITE / READ
//     d) ref_pending>0, no requests               -> load REFRESH
//     e) otherwise                                -> stay IDLE
//     Loading: cmd_op/addr/data registered, cmd_valid<=1, state<=ISSUE. The matching ack pulses
//     in that same cycle (no ack for refresh). last_grant updates only on WRITE/READ loads.
//   ISSUE: cmd_valid and all cmd_* held stable until cmd_valid&cmd_ready. On that edge:
//     cmd_valid<=0, state<=IDLE. If cmd_op==REFRESH, ref_pending-1.
// - A tick on the same edge as a refresh acceptance leaves ref_pending unchanged (+1-1).
//   At ref_pending==MAX_PENDING this nets to MAX_PENDING and does not set overflow.
// - Throughput: at most one command per 2 cycles. The cycle after acceptance is always IDLE.
// - Latency: req seen in IDLE at edge N -> ack high after N, cmd_valid high after N;
//   the earliest acceptance is at edge N+1.
// - Requests arriving during ISSUE wait; they are not acked until granted from IDLE.
// - cmd_ready is ignored while cmd_valid=0.
// TESTING
// 1 Reset: hold reset_n=0 for 3 clk -> every output 0. Release -> first tick after 1296 cycles
//   sets ref_pending=1.
// 2 Single write: wr_req, addr=0x12345, data=0xDEADBEEF, cmd_ready=1 -> wr_ack 1 cycle,
//   cmd_valid 1 cycle with op=00 and matching addr/data. Controller stall of 5 cycles (ready=0)
//   -> cmd fields stable for all 5.
// 3 Round-robin: wr_req and rd_req held continuously, ready=1 -> ops alternate W,R,W,R
//   (write first after reset), one command every 2 cycles.
// 4 Deferred refresh: REFRESH_INTERVAL=16, continuous rd_req -> ref_pending climbs to 8,
//   then op=10 is issued before the next read; ref_pending drops to 7.
// 5 Overflow: interval 16, ready=0 for 200 cycles -> ref_pending saturates at 8 and
//   ref_overflow=1 stays set after ready returns to 1.
// 6 Idle refresh: no requests, ref_pending=1 -> one op=10 command, then ref_pending=0 and
//   cmd_valid stays 0.

Source files
------------

// File: rtl/sdram_req_scheduler.sv
// Front-end command scheduler for the SDRAM controller.
// Arbitrates write, read and periodic refresh into one registered command stream.
module sdram_req_scheduler #(
  parameter int ADDR_WIDTH       = 23,
  parameter int DATA_WIDTH       = 32,
  parameter int REFRESH_INTERVAL = 1296,
  parameter int MAX_PENDING      = 8,
  localparam int PW = $clog2(MAX_PENDING + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ack,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_ack,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [1:0]            cmd_op,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic [DATA_WIDTH-1:0] cmd_data,
  output logic [PW-1:0]         ref_pending,
  output logic                  ref_overflow
);

  localparam int CW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_INTERVAL - 1);
  localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING);
  localparam logic [1:0] OP_WR  = 2'b00;
  localparam logic [1:0] OP_RD  = 2'b01;
  localparam logic [1:0] OP_REF = 2'b10;

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt;
  logic                  w_tick;
  logic [PW-1:0]         r_pend;
  logic                  r_ovf;
  logic                  r_valid, w_valid_nxt;
  logic [1:0]            r_op, w_op_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [DATA_WIDTH-1:0] r_data, w_data_nxt;
  logic                  r_wr_ack, w_wr_ack_nxt;
  logic                  r_rd_ack, w_rd_ack_nxt;
  logic                  r_last_wr, w_last_wr_nxt;
  logic                  w_ref_done;

  assign w_tick     = (r_cnt == CNT_LAST);
  assign w_ref_done = (r_state == S_ISSUE) && r_valid
                   && cmd_ready && (r_op == OP_REF);

  always_comb begin
    w_state_nxt   = r_state;
    w_valid_nxt   = r_valid;
    w_op_nxt      = r_op;
    w_addr_nxt    = r_addr;
    w_data_nxt    = r_data;
    w_wr_ack_nxt  = 1'b0;
    w_rd_ack_nxt  = 1'b0;
    w_last_wr_nxt = r_last_wr;
    unique case (r_state)
      S_IDLE: begin
        // a full backlog beats traffic; otherwise traffic beats refresh
        if (r_pend == PEND_MAX) begin
          w_state_nxt = S_ISSUE;
          w_valid_nxt = 1'b1;
          w_op_nxt    = OP_REF;
          w_addr_nxt  = '0;
          w_data_nxt  = '0;
        end else if (wr_req && (!rd_req || !r_last_wr)) begin
          w_state_nxt   = S_ISSUE;
          w_valid_nxt   = 1'b1;
          w_op_nxt      = OP_WR;
          w_addr_nxt    = wr_addr;
          w_data_nxt    = wr_data;
          w_wr_ack_nxt  = 1'b1;
          w_last_wr_nxt = 1'b1;
        end else if (rd_req) begin
          w_state_nxt   = S_ISSUE;
          w_valid_nxt   = 1'b1;
          w_op_nxt      = OP_RD;
          w_addr_nxt    = rd_addr;
          w_data_nxt    = '0;
          w_rd_ack_nxt  = 1'b1;
          w_last_wr_nxt = 1'b0;
        end else if (r_pend != '0) begin
          w_state_nxt = S_ISSUE;
          w_valid_nxt = 1'b1;
          w_op_nxt    = OP_REF;
          w_addr_nxt  = '0;
          w_data_nxt  = '0;
        end
      end
      S_ISSUE: begin
        if (r_valid && cmd_ready) begin
          w_state_nxt = S_IDLE;
          w_valid_nxt = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_pend    <= '0;
      r_ovf     <= 1'b0;
      r_valid   <= 1'b0;
      r_op      <= 2'b00;
      r_addr    <= '0;
      r_data    <= '0;
      r_wr_ack  <= 1'b0;
      r_rd_ack  <= 1'b0;
      r_last_wr <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_valid   <= w_valid_nxt;
      r_op      <= w_op_nxt;
      r_addr    <= w_addr_nxt;
      r_data    <= w_data_nxt;
      r_wr_ack  <= w_wr_ack_nxt;
      r_rd_ack  <= w_rd_ack_nxt;
      r_last_wr <= w_last_wr_nxt;
      r_cnt     <= w_tick ? '0 : r_cnt + CW'(1);
      // tick and refresh completion on one edge cancel out
      if (w_tick && !w_ref_done) begin
        if (r_pend != PEND_MAX) r_pend <= r_pend + PW'(1);
        else                    r_ovf  <= 1'b1;
      end else if (!w_tick && w_ref_done) begin
        r_pend <= r_pend - PW'(1);
      end
    end
  end

  assign wr_ack       = r_wr_ack;
  assign rd_ack       = r_rd_ack;
  assign cmd_valid    = r_valid;
  assign cmd_op       = r_op;
  assign cmd_addr     = r_addr;
  assign cmd_data     = r_data;
  assign ref_pending  = r_pend;
  assign ref_overflow = r_ovf;

endmodule
